// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } dmem_state_e;

  // RISC-V load/store funct3 encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the access cannot be served: halfword on an odd byte,
  // word off a 4-byte boundary, or an encoding outside the legal set.
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = lane[0];
      F3_W:        bad = (lane != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction and sign/zero extension from a held 32-bit word.
// Latency: combinational.
// Backpressure: none.
// Ports: word (held memory word), lane (byte offset), funct3 (size/sign),
//        data (extended result).
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
    // lane[0] is ignored for halfwords: aligned down when checking is off.
    half_sel = lane[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word stores in one cycle, loads returned
// two cycles after acceptance with sign/zero extension.
// Latency: store commits at end of accept cycle; load rd_valid at N+2.
// Backpressure: busy=1 while a load is in flight; requests then are dropped.
// Ports: clk, reset (sync, active-high), rd/wr/addr/funct3/wr_data request,
//        rd_data/rd_valid load response, busy, misalign_err (1-cycle pulse).
// Build option: DMEM_MISALIGN_CHECK_EN enables misalignment / illegal funct3
//        / rd+wr conflict detection; without it misalign_err is tied 0,
//        accesses are aligned down, illegal funct3 acts as word and a
//        simultaneous rd+wr performs only the store.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              misalign_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  // Four byte lanes; contents survive reset.
  logic [7:0] mem_q [4][DEPTH];

  dmem_state_e       state_q,   state_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [1:0]        lane_q,    lane_d;
  logic [2:0]        f3_q,      f3_d;
  logic [31:0]       hold_q,    hold_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q,    busy_d;
  logic              err_q,     err_d;

  logic [3:0]        we;
  logic [3:0]        lane_mask;
  logic [3:0][7:0]   wr_lanes;
  logic [2:0]        f3_eff;
  logic [31:0]       mem_word;
  logic [31:0]       align_data;

  // Store byte-enable and lane-replicated data. Illegal encodings fall into
  // the word case, which is what the unchecked build wants.
  always_comb begin
    lane_mask = 4'b1111;
    wr_lanes  = wr_data[31:0];
    f3_eff    = funct3;
    case (funct3)
      F3_B, F3_BU: begin
        lane_mask = 4'b0001 << addr[1:0];
        wr_lanes  = {4{wr_data[7:0]}};
      end
      F3_H, F3_HU: begin
        lane_mask = addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes  = {2{wr_data[15:0]}};
      end
      F3_W: begin
        lane_mask = 4'b1111;
      end
      default: begin
        lane_mask = 4'b1111;
        f3_eff    = F3_W;
      end
    endcase
  end

  assign mem_word = {mem_q[3][idx_q], mem_q[2][idx_q],
                     mem_q[1][idx_q], mem_q[0][idx_q]};

  dmem_load_align u_align (
    .word   (hold_q),
    .lane   (lane_q),
    .funct3 (f3_q),
    .data   (align_data)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    f3_d       = f3_q;
    hold_d     = hold_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    we         = 4'b0000;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (rd && wr) begin
          err_d = 1'b1;
        end else if ((rd || wr) && misaligned(funct3, addr[1:0])) begin
          err_d = 1'b1;
        end else if (wr) begin
          we = lane_mask;
        end else if (rd) begin
          state_d = RD_WAIT;
          busy_d  = 1'b1;
          idx_d   = addr[ADDR_W-1:2];
          lane_d  = addr[1:0];
          f3_d    = f3_eff;
        end
`else
        if (wr) begin
          we = lane_mask;
        end else if (rd) begin
          state_d = RD_WAIT;
          busy_d  = 1'b1;
          idx_d   = addr[ADDR_W-1:2];
          lane_d  = addr[1:0];
          f3_d    = f3_eff;
        end
`endif
      end
      RD_WAIT: begin
        hold_d     = mem_word;
        state_d    = RD_RESP;
        rd_valid_d = 1'b1;
        busy_d     = 1'b1;
      end
      RD_RESP: begin
        rd_data_d = align_data;
        state_d   = IDLE;
        busy_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lane_q     <= 2'b00;
      f3_q       <= F3_W;
      hold_q     <= 32'h0;
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      f3_q       <= f3_d;
      hold_q     <= hold_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_q[i][addr[ADDR_W-1:2]] <= wr_lanes[i];
      end
    end
  end

  // During RD_RESP the fresh extraction is presented directly; afterwards
  // the registered copy keeps rd_data stable until the next response.
  assign rd_data  = (state_q == RD_RESP) ? align_data : rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the memory-side end of the core's `wr`/`rd`/`addr`/`wr_data`/`rd_data` load/store interface. It accepts byte-addressed load/store requests of byte, halfword or word size. Stores commit in one cycle. Loads return sign- or zero-extended data after a fixed two-cycle latency, with a busy indication. It sits between the core datapath and its 512-byte data store, replacing a bare combinational RAM.

## Interface
Parameters:
- `DATA_W`, 32, data width; only 32 supported.
- `ADDR_W`, 9, byte-address width; depth = 2**(ADDR_W-2) words (128).

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high.
- `rd`  in  1  load request.
- `wr`  in  1  store request.
- `addr`  in  ADDR_W  byte address.
- `funct3`  in  3  access size/sign, RISC-V encoding.
- `wr_data`  in  DATA_W  store data, right-justified.
- `rd_data`  out  DATA_W  extended load data.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid.
- `busy`  out  1  load in flight; requests ignored.
- `misalign_err`  out  1  one-cycle pulse, request rejected.

## Operation
- Storage is four byte lanes of depth words. Word index = `addr[ADDR_W-1:2]`, lane = `addr[1:0]`.
- Encodings:
  - `funct3` 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Any other value is illegal and handled like a misalignment.
- FSM states IDLE, RD_WAIT, RD_RESP.
  - IDLE with `wr` and not `rd`: write byte lanes per size.
    - SB: lane `addr[1:0]` ← `wr_data[7:0]`.
    - SH: lanes `addr[1]*2`, +1 ← `wr_data[15:0]`.
    - SW: all lanes.
    - State stays IDLE.
  - IDLE with `rd` and not `wr`: latch word index, lane and `funct3`; go to RD_WAIT.
  - RD_WAIT: read the addressed word into a holding register; go to RD_RESP.
  - RD_RESP: drive the extracted, extended value on `rd_data`; `rd_valid`=1; return to IDLE.
- `rd_data` holds its value until the next RD_RESP.
- Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- `rd` and `wr` both high in IDLE: illegal. `misalign_err` pulses; no write, no read.
- Requests presented while `busy`=1 are ignored silently: no write, no error.
- Misalignment: halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or illegal `funct3`. Result is a `misalign_err` pulse the next cycle, no state change, and no array modification.
- Address wrap: none needed; every `addr` value maps inside the array.

## Timing
- Reset values: state IDLE, `rd_data`=0, `rd_valid`=0, `busy`=0, `misalign_err`=0. Array contents are not cleared.
- Store accepted cycle N: the array updates at the end of N. A load accepted at N+1 sees the new data.
- Load accepted cycle N:
  - `busy`=1 in N+1 and N+2.
  - `rd_valid`=1 and `rd_data` valid in N+2.
  - Next request is accepted in N+3.
- Maximum load throughput is one per three cycles.
- `busy` is a registered output and deasserts in the cycle after RD_RESP.
- `misalign_err`: registered, asserted for exactly the cycle after the offending request.
- Reset during RD_WAIT or RD_RESP:
  - Next cycle is IDLE with all outputs at reset values.
  - No `rd_valid` pulse for the abandoned load.
  - Array untouched.

## Configuration
- `DMEM_MISALIGN_CHECK_EN`.
  - Defined: misalignment and illegal-`funct3` detection as above; `misalign_err` is driven.
  - Undefined: no checking and `misalign_err` is tied 0.
    - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]` (aligned down).
    - Illegal `funct3` is treated as word.
    - `rd` and `wr` both high: the store wins and no load is started.

## Structure
- `dmem_pkg` holds:
  - state enum (`IDLE`, `RD_WAIT`, `RD_RESP`);
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `misaligned(funct3, addr[1:0])` function.
- Sub-module `dmem_load_align`: combinational lane extraction plus sign/zero extension from the held word, lane and `funct3`. Used only in RD_RESP.

## Test plan
- SW `0xDEADBEEF` @ `0x010`, then LW @ `0x010` → `rd_valid` at +2 cycles, `rd_data`=`0xDEADBEEF`; `busy` high exactly 2 cycles.
- SB `0x80` @ `0x013`, then LB @ `0x013` → `0xFFFFFF80`; LBU @ `0x013` → `0x00000080`; LW @ `0x010` → `0x80ADBEEF`.
- SH `0x8001` @ `0x022`, then LH → `0xFFFF8001`, LHU → `0x00008001`; word @ `0x020` lanes 0–1 unchanged.
- With `DMEM_MISALIGN_CHECK_EN`:
  - LW @ `0x012` → `misalign_err` pulse next cycle, no `rd_valid`.
  - SH @ `0x021` → array unchanged.
  - `rd`=`wr`=1 → error pulse.
- Store issued while `busy` → ignored; a following LW returns the old value.
- `reset` asserted in RD_WAIT → no `rd_valid`. All outputs are 0 next cycle and a fresh LW returns the previously stored data.
